// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU codes, width default and FSM encoding (SEQ_ALU_FAST_SHIFT_EN selects barrel shifting)
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

`ifdef SEQ_ALU_FAST_SHIFT_EN
   localparam bit FAST_SHIFT = 1'b1;
`else
   localparam bit FAST_SHIFT = 1'b0;
`endif

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// rtl/seq_alu_shifter.sv - shift datapath, serial one-bit-per-cycle or barrel when SEQ_ALU_FAST_SHIFT_EN is defined
module seq_alu_shifter
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] din,
   input  logic [4:0]      shamt,
   output logic [XLEN-1:0] result,
   output logic            last
);

`ifdef SEQ_ALU_FAST_SHIFT_EN
   // Whole shift resolved in one cycle from the live request operands.
   always_comb begin
      result = din;
      case (op)
         ALU_SLL: result = din << shamt;
         ALU_SRL: result = din >> shamt;
         ALU_SRA: result = $signed(din) >>> shamt;
         default: result = din;
      endcase
   end

   assign last = 1'b0;
`else
   logic [XLEN-1:0] shreg;
   logic [4:0]      cnt;
   logic            left_q;
   logic            fill_q;

   // Load operand and count on accept, then shift one bit per cycle until the count is spent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg  <= '0;
         cnt    <= 5'd0;
         left_q <= 1'b0;
         fill_q <= 1'b0;
      end else if (load) begin
         shreg  <= din;
         cnt    <= shamt;
         left_q <= (op == ALU_SLL);
         fill_q <= (op == ALU_SRA) & din[XLEN-1];
      end else if (cnt != 5'd0) begin
         shreg <= left_q ? {shreg[XLEN-2:0], 1'b0} : {fill_q, shreg[XLEN-1:1]};
         cnt   <= cnt - 5'd1;
      end
   end

   assign result = shreg;
   // The final bit moves on the same edge that takes the FSM to DONE.
   assign last   = (cnt == 5'd1);
`endif

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked sequential ALU top (SEQ_ALU_FAST_SHIFT_EN removes the SHIFT state)
module seq_alu
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      ALUControl,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ALUResult,
   output logic            Zero,
   output logic            illegal
);

   state_t          state_q;
   state_t          next_state;
   logic [XLEN-1:0] result_q;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] shift_res;
   logic            illegal_q;
   logic            sel_shift_q;
   logic            legal;
   logic            accept;
   logic            go_shift;
   logic            shift_last;
   logic [4:0]      shamt;

   assign shamt    = SrcB[4:0];
   assign accept   = in_valid & in_ready;
   assign go_shift = is_shift(ALUControl) && !FAST_SHIFT && (shamt != 5'd0);

   seq_alu_shifter #(.XLEN(XLEN)) u_shifter (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (accept & go_shift),
      .op      (ALUControl),
      .din     (SrcA),
      .shamt   (shamt),
      .result  (shift_res),
      .last    (shift_last)
   );

   // Single-cycle result for every op that completes straight into DONE.
   always_comb begin
      alu_res = '0;
      legal   = 1'b1;
      case (ALUControl)
         ALU_ADD:  alu_res = SrcA + SrcB;
         ALU_SUB:  alu_res = SrcA - SrcB;
         ALU_AND:  alu_res = SrcA & SrcB;
         ALU_OR:   alu_res = SrcA | SrcB;
         ALU_XOR:  alu_res = SrcA ^ SrcB;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
         ALU_SLL, ALU_SRL, ALU_SRA:
                   alu_res = FAST_SHIFT ? shift_res : SrcA;
         default:  legal = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= next_state;
   end

   // Next-state and handshake outputs.
   always_comb begin
      next_state = state_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = go_shift ? ST_SHIFT : ST_DONE;
         end
         ST_SHIFT: begin
            if (shift_last) next_state = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Capture the result and flags only on accept; they hold until the next accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result_q    <= '0;
         illegal_q   <= 1'b0;
         sel_shift_q <= 1'b0;
      end else if (accept) begin
         sel_shift_q <= go_shift;
         result_q    <= go_shift ? '0 : alu_res;
         illegal_q   <= ~legal;
      end
   end

   assign ALUResult = sel_shift_q ? shift_res : result_q;
   assign Zero      = (ALUResult == '0);
   assign illegal   = illegal_q & out_valid;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized self-checking bench for seq_alu (honours SEQ_ALU_FAST_SHIFT_EN)
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  ALUControl;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        illegal;

   int n_checks = 0;
   int n_pass   = 0;

   seq_alu #(.XLEN(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALUControl (ALUControl),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, output logic ill);
      logic [31:0] r;
      int          sh;
      sh  = int'(b[4:0]);
      ill = 1'b0;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a << sh;
         4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    r = (a < b) ? 32'd1 : 32'd0;
         4'd7:    r = a ^ b;
         4'd8:    r = a >> sh;
         4'd9:    r = $signed(a) >>> sh;
         default: begin r = 32'd0; ill = 1'b1; end
      endcase
      return r;
   endfunction

   function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef SEQ_ALU_FAST_SHIFT_EN
      return 1;
`else
      if ((op == 4'd4 || op == 4'd8 || op == 4'd9) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
      return 1;
`endif
   endfunction

   task automatic scramble();
      ALUControl = 4'($urandom);
      SrcA       = $urandom;
      SrcB       = $urandom;
      in_valid   = 1'($urandom_range(0, 1));
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
      logic [31:0] er;
      logic        eill;
      int          elat;
      int          lat;
      logic        rdy_low;
      er   = model(op, a, b, eill);
      elat = model_latency(op, b);
      @(negedge clk);
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      in_valid   = 1'b1;
      ALUControl = op;
      SrcA       = a;
      SrcB       = b;
      out_ready  = 1'b0;
      @(posedge clk); #1;
      scramble();
      lat     = 1;
      rdy_low = 1'b1;
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy_low = 1'b0;
         @(posedge clk); #1;
         scramble();
         lat++;
      end
      check("latency", 32'(lat), 32'(elat));
      check("result", ALUResult, er);
      check("zero", {31'd0, Zero}, {31'd0, (er == 32'd0)});
      check("illegal", {31'd0, illegal}, {31'd0, eill});
      check("busy_not_ready", {31'd0, rdy_low}, 32'd1);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         scramble();
         check("hold_result", ALUResult, er);
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("post_handshake_valid", {31'd0, out_valid}, 32'd0);
      check("post_handshake_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic seen;
      logic [3:0]  op;
      logic [31:0] b;
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      ALUControl = 4'd0;
      SrcA       = 32'd0;
      SrcB       = 32'd0;
      #12;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result", ALUResult, 32'd0);
      check("reset_zero", {31'd0, Zero}, 32'd1);
      check("reset_illegal", {31'd0, illegal}, 32'd0);
      @(posedge clk); #2;
      reset_n = 1'b1;

      run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(4'd9, 32'h8000_0000, 32'd31, 2);
      run_op(4'd5, 32'hFFFF_FFFE, 32'd1, 0);
      run_op(4'd6, 32'hFFFF_FFFE, 32'd1, 0);
      run_op(4'b1100, $urandom, $urandom, 1);
      run_op(4'd4, 32'd1, 32'd4, 5);
      run_op(4'd8, 32'hF000_000F, 32'd0, 0);

      @(negedge clk);
      in_valid   = 1'b1;
      ALUControl = 4'd8;
      SrcA       = $urandom;
      SrcB       = 32'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_result", ALUResult, 32'd0);
      check("abort_zero", {31'd0, Zero}, 32'd1);
      @(posedge clk); #2;
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_result", {31'd0, seen}, 32'd0);

      for (int k = 0; k < 40; k++) begin
         op = 4'($urandom_range(0, 15));
         b  = $urandom;
         if (k % 3 == 0) b[4:0] = 5'($urandom_range(0, 3));
         run_op(op, $urandom, b, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 ALUControl  input  4  operation code from the ALU decoder.
REQ-007 SrcA  input  XLEN  operand A.
REQ-008 SrcB  input  XLEN  operand B; SrcB[4:0] is the shift amount for shifts.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 ALUResult  output  XLEN  registered result.
REQ-012 Zero  output  1  high when ALUResult == 0.
REQ-013 illegal  output  1  high with out_valid when the captured code was undefined.

Function
REQ-014 Codes SHALL be: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SLT 0101, SLTU 0110, XOR 0111, SRL 1000, SRA 1001; 1010-1111 undefined.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-016 Accept occurs when in_valid & in_ready; ALUControl, SrcA, SrcB are captured only then, and later input changes are ignored.
REQ-017 Non-shift legal op: IDLE -> DONE; out_valid is asserted the cycle after accept (latency 1).
REQ-018 Shift op with shamt 0: IDLE -> DONE, result = SrcA, latency 1.
REQ-019 Shift op with shamt N > 0: IDLE -> SHIFT; shift one bit per cycle, decrementing a 5-bit counter; SHIFT -> DONE when the counter reaches 0; out_valid is asserted N+1 cycles after accept.
REQ-020 SRA fills with captured SrcA[XLEN-1]; SLL/SRL fill with 0.
REQ-021 ADD/SUB wrap modulo 2^XLEN with no overflow flag.
REQ-022 SLT is a signed compare and SLTU an unsigned compare; the result is 1 or 0, zero-extended to XLEN.
REQ-023 Undefined code: IDLE -> DONE, ALUResult = 0, illegal = 1, latency 1.
REQ-024 In DONE, ALUResult, Zero and illegal SHALL hold stable until out_valid & out_ready, then DONE -> IDLE.
REQ-025 No back-to-back acceptance: a new request is accepted at earliest the cycle after the DONE handshake.

Reset
REQ-026 reset_n low SHALL immediately force state IDLE, in_ready = 1, out_valid = 0, ALUResult = 0, Zero = 1, illegal = 0, shift counter = 0.
REQ-027 reset_n asserted mid-SHIFT or in DONE SHALL abort the operation; the pending result is discarded.
REQ-028 Release is synchronous-safe: the first accept can occur on the first rising edge with reset_n high.

Configuration
REQ-029 Macro SEQ_ALU_FAST_SHIFT_EN defined: shifts use a combinational barrel shifter, SHIFT state is never entered, all legal ops have latency 1.
REQ-030 Macro undefined: serial shifting per REQ-019; the functional result is identical in both builds.

Structure
REQ-031 Package alu_pkg SHALL hold the ALUControl code constants, the XLEN default, and the FSM state encoding; it is shared with the ALU decoder.
REQ-032 One sub-module, seq_alu_shifter, SHALL hold the shift register, counter and fill logic (serial or barrel per macro).
REQ-033 Datapath ops other than shifts stay in seq_alu.

Verification
REQ-034 ADD SrcA=0xFFFFFFFF, SrcB=1 -> out_valid 1 cycle after accept, ALUResult=0, Zero=1.
REQ-035 SRA SrcA=0x80000000, SrcB=31 -> serial: out_valid 32 cycles after accept; fast: 1 cycle; ALUResult=0xFFFFFFFF.
REQ-036 SLT SrcA=0xFFFFFFFE, SrcB=1 -> result 1; SLTU with the same operands -> result 0.
REQ-037 ALUControl=1100 -> ALUResult=0, illegal=1, latency 1.
REQ-038 SLL SrcA=1, SrcB=4, out_ready held low 5 cycles -> result 0x10 held stable, in_ready=0 throughout; idle one cycle after handshake.
REQ-039 reset_n pulsed low mid-SHIFT (SRL shamt 20, cycle 5) -> IDLE, out_valid=0, no result emitted.
